// File: rtl/lut_config_loader.sv
// Serial configuration loader for a 16:1 LUT: shifts a bitstream into a shadow
// register, checks even parity, then commits the whole truth table in one edge.
module lut_config_loader #(
    parameter int WIDTH     = 16,
    parameter bit PARITY_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_start,
    input  logic             cfg_bit,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    output logic             cfg_bit_out,
    input  logic             lut_disable,
    output logic [WIDTH-1:0] lut_config,
    output logic             lut_en,
    output logic             cfg_done,
    output logic             cfg_err,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2,
        COMMIT = 2'd3
    } state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] shadow_reg;
    logic [WIDTH-1:0] shadow_next;
    logic [CW-1:0]    count_reg;
    logic             beat;
    logic             parity_ok;

    // New bits enter at the top so the first bit sent ends up in bit 0.
    generate
        for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_shift
            assign shadow_next[gi] = shadow_reg[gi+1];
        end
    endgenerate
    assign shadow_next[WIDTH-1] = cfg_bit;

    assign cfg_ready = (state_reg == SHIFT) || (state_reg == PARITY);
    assign busy      = (state_reg != IDLE);
    assign beat      = cfg_valid && cfg_ready;
    assign parity_ok = ((^shadow_reg) ^ cfg_bit) == 1'b0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            shadow_reg  <= '0;
            count_reg   <= '0;
            lut_config  <= '0;
            lut_en      <= 1'b0;
            cfg_bit_out <= 1'b0;
            cfg_done    <= 1'b0;
            cfg_err     <= 1'b0;
        end else begin
            cfg_done <= 1'b0;
            cfg_err  <= 1'b0;
            if (lut_disable) begin
                lut_en <= 1'b0;
            end

            case (state_reg)
                IDLE: begin
                    if (cfg_start) begin
                        shadow_reg <= '0;
                        count_reg  <= '0;
                        state_reg  <= SHIFT;
                    end
                end

                SHIFT: begin
                    // A restart outranks any beat presented on the same edge.
                    if (cfg_start) begin
                        shadow_reg <= '0;
                        count_reg  <= '0;
                    end else if (beat) begin
                        shadow_reg  <= shadow_next;
                        cfg_bit_out <= shadow_reg[0];
                        count_reg   <= count_reg + CW'(1);
                        if (count_reg == LAST_BEAT) begin
                            state_reg <= PARITY_EN ? PARITY : COMMIT;
                        end
                    end
                end

                PARITY: begin
                    if (cfg_start) begin
                        shadow_reg <= '0;
                        count_reg  <= '0;
                        state_reg  <= SHIFT;
                    end else if (beat) begin
                        if (parity_ok) begin
                            state_reg <= COMMIT;
                        end else begin
                            cfg_err   <= 1'b1;
                            state_reg <= IDLE;
                        end
                    end
                end

                COMMIT: begin
                    // Disable only suppresses the enable; the table still commits.
                    lut_config <= shadow_reg;
                    lut_en     <= ~lut_disable;
                    cfg_done   <= 1'b1;
                    state_reg  <= IDLE;
                end

                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule
